// File: rtl/mux_scan_nch.sv
//------------------------------------------------------------------------------
// Module   : mux_scan_nch
// Brief    : Time-multiplexed N-channel digit scanner with gap ticks, masking,
//            leading-zero blanking and frame-synchronous double-buffered data.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_scan_nch #(
    parameter int             NUM_CH    = 6,
    parameter int             W         = 4,
    parameter int             PRESCALE  = 1000,
    parameter int             GAP_TICKS = 1,
    parameter logic [W-1:0]   BLANK_VAL = 4'hF,
    localparam int            SEL_W     = $clog2(NUM_CH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_load,
    input  logic [NUM_CH*W-1:0]   i_data,
    input  logic [NUM_CH-1:0]     i_mask,
    input  logic                  i_lzb,
    output logic [W-1:0]          o_data,
    output logic [SEL_W-1:0]      o_sel,
    output logic [NUM_CH-1:0]     o_digit_en,
    output logic                  o_frame
);

    localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    localparam logic [c_PW-1:0]  c_PRESC_MAX = c_PW'(PRESCALE - 1);
    localparam logic [c_GW-1:0]  c_GAP_MAX   = c_GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [SEL_W-1:0] c_LAST      = SEL_W'(NUM_CH - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACTIVE = 2'd1;
    localparam logic [1:0] c_GAP    = 2'd2;

    // Scan sequencing state
    logic [1:0]           r_state;
    logic [SEL_W-1:0]     r_idx;
    logic [c_PW-1:0]      r_presc;
    logic [c_GW-1:0]      r_gap_cnt;

    // Shadow (written by i_load) and display (used for output) buffers
    logic                 r_pending;
    logic [NUM_CH*W-1:0]  r_shadow_data;
    logic [NUM_CH-1:0]    r_shadow_mask;
    logic                 r_shadow_lzb;
    logic [NUM_CH*W-1:0]  r_disp_data;
    logic [NUM_CH-1:0]    r_disp_mask;
    logic                 r_disp_lzb;

    // Registered outputs
    logic [W-1:0]         r_out_data;
    logic [SEL_W-1:0]     r_out_sel;
    logic [NUM_CH-1:0]    r_out_den;
    logic                 r_out_frame;

    logic [1:0]           w_state_nxt;
    logic [SEL_W-1:0]     w_idx_nxt;
    logic [c_PW-1:0]      w_presc_nxt;
    logic [c_GW-1:0]      w_gap_nxt;
    logic                 w_tick;
    logic                 w_advance;
    logic                 w_boundary;

    logic                 w_pending_nxt;
    logic [NUM_CH*W-1:0]  w_disp_data_nxt;
    logic [NUM_CH-1:0]    w_disp_mask_nxt;
    logic                 w_disp_lzb_nxt;

    logic                 w_run;
    logic [NUM_CH*W-1:0]  w_ch_val;
    logic [W-1:0]         w_sel_val;
    logic [NUM_CH-1:0]    w_den_nxt;
    logic [W-1:0]         w_data_nxt;

    assign w_tick = (r_presc == c_PRESC_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_presc_nxt = r_presc;
        w_gap_nxt   = r_gap_cnt;
        w_advance   = 1'b0;
        w_boundary  = 1'b0;

        if (!i_en) begin
            w_state_nxt = c_IDLE;
            w_idx_nxt   = '0;
            w_presc_nxt = '0;
            w_gap_nxt   = '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    w_state_nxt = c_ACTIVE;
                    w_idx_nxt   = '0;
                    w_presc_nxt = '0;
                    w_gap_nxt   = '0;
                    w_boundary  = 1'b1;
                end
                c_ACTIVE: begin
                    w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) begin
                        if (GAP_TICKS == 0) begin
                            w_advance = 1'b1;
                        end else begin
                            w_state_nxt = c_GAP;
                            w_gap_nxt   = '0;
                        end
                    end
                end
                c_GAP: begin
                    w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) begin
                        if (r_gap_cnt == c_GAP_MAX) begin
                            w_state_nxt = c_ACTIVE;
                            w_gap_nxt   = '0;
                            w_advance   = 1'b1;
                        end else begin
                            w_gap_nxt = r_gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_idx_nxt   = '0;
                    w_presc_nxt = '0;
                    w_gap_nxt   = '0;
                end
            endcase

            // Wrapping from the last channel starts a new frame
            if (w_advance) begin
                if (r_idx == c_LAST) begin
                    w_idx_nxt  = '0;
                    w_boundary = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
        end
    end

    // Display buffer only changes on a frame boundary; a load on that very edge bypasses the shadow
    always_comb begin
        w_disp_data_nxt = r_disp_data;
        w_disp_mask_nxt = r_disp_mask;
        w_disp_lzb_nxt  = r_disp_lzb;
        w_pending_nxt   = r_pending;
        if (w_boundary) begin
            w_pending_nxt = 1'b0;
            if (i_load) begin
                w_disp_data_nxt = i_data;
                w_disp_mask_nxt = i_mask;
                w_disp_lzb_nxt  = i_lzb;
            end else if (r_pending) begin
                w_disp_data_nxt = r_shadow_data;
                w_disp_mask_nxt = r_shadow_mask;
                w_disp_lzb_nxt  = r_shadow_lzb;
            end
        end else if (i_load) begin
            w_pending_nxt = 1'b1;
        end
    end

    // w_run tracks "this channel and every more significant one are zero"
    always_comb begin
        w_run    = 1'b1;
        w_ch_val = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            w_run = w_run & (w_disp_data_nxt[c*W +: W] == '0);
            if (w_disp_mask_nxt[c] || (w_disp_lzb_nxt && (c > 0) && w_run)) begin
                w_ch_val[c*W +: W] = BLANK_VAL;
            end else begin
                w_ch_val[c*W +: W] = w_disp_data_nxt[c*W +: W];
            end
        end
    end

    always_comb begin
        w_sel_val = BLANK_VAL;
        w_den_nxt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_idx_nxt == SEL_W'(c)) begin
                w_sel_val    = w_ch_val[c*W +: W];
                w_den_nxt[c] = (w_state_nxt == c_ACTIVE);
            end
        end
    end

    assign w_data_nxt = (w_state_nxt == c_ACTIVE) ? w_sel_val : BLANK_VAL;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= c_IDLE;
            r_idx         <= '0;
            r_presc       <= '0;
            r_gap_cnt     <= '0;
            r_pending     <= 1'b0;
            r_shadow_data <= {NUM_CH{BLANK_VAL}};
            r_shadow_mask <= '0;
            r_shadow_lzb  <= 1'b0;
            r_disp_data   <= {NUM_CH{BLANK_VAL}};
            r_disp_mask   <= '0;
            r_disp_lzb    <= 1'b0;
            r_out_data    <= BLANK_VAL;
            r_out_sel     <= '0;
            r_out_den     <= '0;
            r_out_frame   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_presc     <= w_presc_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_pending   <= w_pending_nxt;
            r_disp_data <= w_disp_data_nxt;
            r_disp_mask <= w_disp_mask_nxt;
            r_disp_lzb  <= w_disp_lzb_nxt;
            if (i_load) begin
                r_shadow_data <= i_data;
                r_shadow_mask <= i_mask;
                r_shadow_lzb  <= i_lzb;
            end
            r_out_data  <= w_data_nxt;
            r_out_sel   <= w_idx_nxt;
            r_out_den   <= w_den_nxt;
            r_out_frame <= w_boundary;
        end
    end

    assign o_data     = r_out_data;
    assign o_sel      = r_out_sel;
    assign o_digit_en = r_out_den;
    assign o_frame    = r_out_frame;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_nch.sv
//------------------------------------------------------------------------------
// Module   : tb_mux_scan_nch
// Brief    : Directed scoreboard bench for mux_scan_nch (6 ch, 4 bit, prescale 4, 1 gap tick).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_scan_nch;

    localparam int NUM_CH = 6;
    localparam int W      = 4;
    localparam int SEL_W  = 3;

    logic                 i_clk;
    logic                 i_rst;
    logic                 i_en;
    logic                 i_load;
    logic [NUM_CH*W-1:0]  i_data;
    logic [NUM_CH-1:0]    i_mask;
    logic                 i_lzb;
    logic [W-1:0]         o_data;
    logic [SEL_W-1:0]     o_sel;
    logic [NUM_CH-1:0]    o_digit_en;
    logic                 o_frame;

    mux_scan_nch #(
        .NUM_CH    (6),
        .W         (4),
        .PRESCALE  (4),
        .GAP_TICKS (1),
        .BLANK_VAL (4'hF)
    ) u_dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_load     (i_load),
        .i_data     (i_data),
        .i_mask     (i_mask),
        .i_lzb      (i_lzb),
        .o_data     (o_data),
        .o_sel      (o_sel),
        .o_digit_en (o_digit_en),
        .o_frame    (o_frame)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct packed {
        logic [W-1:0]      d;
        logic [SEL_W-1:0]  s;
        logic [NUM_CH-1:0] e;
        logic              f;
    } exp_t;

    exp_t  q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string tag   = "init";

    task automatic push(input logic [W-1:0] d, input logic [SEL_W-1:0] s,
                        input logic [NUM_CH-1:0] e, input logic f);
        exp_t x;
        x.d = d; x.s = s; x.e = e; x.f = f;
        q.push_back(x);
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) push(4'hF, '0, '0, 1'b0);
    endtask

    // First n cycles of a frame whose channels show the nibbles of 'shown' (ch0 = LSB)
    task automatic push_part(input logic [NUM_CH*W-1:0] shown, input int n);
        int k;
        k = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int j = 0; j < 8; j++) begin
                if (k < n) begin
                    if (j < 4)
                        push(shown[c*W +: W], SEL_W'(c), NUM_CH'(1) << c, (c == 0) && (j == 0));
                    else
                        push(4'hF, SEL_W'(c), '0, 1'b0);
                end
                k++;
            end
        end
    endtask

    task automatic check_now();
        exp_t got, ex;
        got = {o_data, o_sel, o_digit_en, o_frame};
        n_cmp++;
        if (q.size() == 0) begin
            n_err++;
            $error("FAIL %s: no expected entry queued, observed %h", tag, got);
        end else begin
            ex = q.pop_front();
            assert (got === ex) else begin
                n_err++;
                $error("FAIL %s cmp#%0d: observed data=%h sel=%0d en=%b frame=%b, expected data=%h sel=%0d en=%b frame=%b",
                       tag, n_cmp, got.d, got.s, got.e, got.f, ex.d, ex.s, ex.e, ex.f);
            end
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
            check_now();
        end
    endtask

    task automatic load(input logic [NUM_CH*W-1:0] d, input logic [NUM_CH-1:0] m, input logic z);
        i_load = 1'b1;
        i_data = d;
        i_mask = m;
        i_lzb  = z;
    endtask

    initial begin
        i_rst  = 1'b0;
        i_en   = 1'b0;
        i_load = 1'b0;
        i_data = '0;
        i_mask = '0;
        i_lzb  = 1'b0;

        // Reset values, checked before any clock edge
        tag = "reset";
        #3 i_rst = 1'b1;
        #1;
        push_idle(1);
        check_now();
        @(posedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        // 1: basic scan, frame period 48
        tag = "t1_idle_load";
        load(24'h543210, 6'b0, 1'b0);
        push_idle(1);
        step(1);
        i_load = 1'b0;
        i_en   = 1'b1;
        tag = "t1_scan";
        push_part(24'h543210, 48);
        push_part(24'h543210, 48);
        step(96);

        // 2: leading-zero blanking
        tag = "t2_lzb_load";
        push_part(24'h543210, 48);
        step(10);
        load(24'h001007, 6'b0, 1'b1);
        step(1);
        i_load = 1'b0;
        step(37);
        tag = "t2_lzb";
        push_part(24'hFF1007, 48);
        step(48);
        tag = "t2_allzero_load";
        push_part(24'hFF1007, 48);
        step(10);
        load(24'h000000, 6'b0, 1'b1);
        step(1);
        i_load = 1'b0;
        step(37);
        tag = "t2_allzero";
        push_part(24'hFFFFF0, 48);
        step(48);

        // 3: mid-frame load waits for the next frame
        tag = "t3_midframe";
        push_part(24'hFFFFF0, 48);
        step(17);
        load(24'h999999, 6'b0, 1'b0);
        step(1);
        i_load = 1'b0;
        step(30);
        tag = "t3_nextframe";
        push_part(24'h999999, 48);
        step(48);

        // 4: load on the wrap edge takes effect immediately, with channel mask
        tag = "t4_bypass_mask";
        push_part(24'h123F56, 48);
        load(24'h123456, 6'b000100, 1'b0);
        step(1);
        i_load = 1'b0;
        step(47);

        // 5: drop enable during a gap, then restart
        tag = "t5_pre";
        push_part(24'h123F56, 6);
        step(6);
        tag = "t5_idle";
        i_en = 1'b0;
        push_idle(3);
        step(3);
        tag = "t5_restart";
        i_en = 1'b1;
        push_part(24'h123F56, 48);
        step(48);

        // 6: asynchronous reset mid-ACTIVE
        tag = "t6_pre";
        push_part(24'h123F56, 26);
        step(26);
        #1 i_rst = 1'b1;
        #1;
        tag = "t6_async_reset";
        push_idle(1);
        check_now();
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        tag = "t6_after_reset";
        push_part(24'hFFFFFF, 48);
        step(48);

        tag = "end";
        n_cmp++;
        assert (q.size() == 0) else begin
            n_err++;
            $error("FAIL %s: observed %0d leftover expected entries, expected 0", tag, q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
